// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder.
//               Holds the responder FSM state encoding and the byte-lane
//               write-enable masks used by the store alignment checker.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Responder FSM state, 2-bit encoded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Legal store lane masks (bit i enables bits 8i+7:8i)
    localparam logic [3:0] LANE_B0 = 4'b0001;
    localparam logic [3:0] LANE_B1 = 4'b0010;
    localparam logic [3:0] LANE_B2 = 4'b0100;
    localparam logic [3:0] LANE_B3 = 4'b1000;
    localparam logic [3:0] LANE_H0 = 4'b0011;
    localparam logic [3:0] LANE_H1 = 4'b1100;
    localparam logic [3:0] LANE_W  = 4'b1111;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : CPU <-> data-memory port bundle.
//   master (CPU)      : drives req, wen, addr, wdata; sees rdata, rvalid,
//                       stall, addr_err
//   slave (responder) : the reverse direction
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;

    logic        req;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stall;
    logic        addr_err;

    modport master (
        output req, wen, addr, wdata,
        input  rdata, rvalid, stall, addr_err
    );

    modport slave (
        input  req, wen, addr, wdata,
        output rdata, rvalid, stall, addr_err
    );

endinterface : dmem_responder_if
`default_nettype wire

// File: rtl/dmem_align_check.sv
`default_nettype none
// ============================================================================
// Module      : dmem_align_check
// Description : Combinational store-alignment classifier.
//   wen_i[3:0]     byte-lane write enables
//   addr_lo_i[1:0] low byte-address bits
//   misaligned_o   1 when the lane pattern is illegal or not naturally aligned
// Note        : an all-zero wen classifies as illegal; the caller only
//               consults this for stores.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_align_check
    import dmem_pkg::*;
(
    input  wire logic [3:0] wen_i,
    input  wire logic [1:0] addr_lo_i,
    output logic            misaligned_o
);

    always_comb begin
        misaligned_o = 1'b1;
        case (wen_i)
            LANE_B0, LANE_B1, LANE_B2, LANE_B3: misaligned_o = 1'b0;
            LANE_H0, LANE_H1:                   misaligned_o = addr_lo_i[0];
            LANE_W:                             misaligned_o = (addr_lo_i != 2'b00);
            default:                            misaligned_o = 1'b1;
        endcase
    end

endmodule : dmem_align_check
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Memory-side responder for the pipeline data-memory port.
//               Accepts one load/store, inserts WAIT_CYCLES wait states,
//               performs the access on an internal word RAM on the edge that
//               enters RESP, and pulses rvalid for one cycle.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (RAM contents are not reset)
//   bus  : dmem_responder_if.slave (req/wen/addr/wdata in,
//          rdata/rvalid/stall/addr_err out)
// Config      : `define DMEM_ALIGN_CHECK_EN to reject misaligned stores and
//               flag them on addr_err; otherwise addr_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dmem_responder_if.slave    bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [ADDR_W+1:0]   addr_q;
    logic [3:0]          wen_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;

    logic [31:0]         mem [DEPTH];

    logic                accept;
    logic                access;
    logic [ADDR_W+1:0]   acc_addr;
    logic [3:0]          acc_wen;
    logic [31:0]         acc_wdata;
    logic [ADDR_W-1:0]   acc_idx;
    logic                acc_is_write;
    logic                acc_misaligned;

    // Upper address bits alias onto the RAM and are deliberately ignored
    logic                unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.addr[31:ADDR_W+2], addr_q[1:0]};

    assign accept = (state_q == IDLE) && bus.req;

    // The access happens on the edge entering RESP.  With zero wait states
    // that edge is the accept edge itself, so the live request is used
    // instead of the (not yet loaded) latched copy.
    assign access    = (state_d == RESP) && (state_q != RESP);
    assign acc_addr  = (state_q == IDLE) ? bus.addr[ADDR_W+1:0] : addr_q;
    assign acc_wen   = (state_q == IDLE) ? bus.wen              : wen_q;
    assign acc_wdata = (state_q == IDLE) ? bus.wdata            : wdata_q;
    assign acc_idx   = acc_addr[ADDR_W+1:2];
    assign acc_is_write = |acc_wen;

`ifdef DMEM_ALIGN_CHECK_EN
    logic chk_misaligned;

    dmem_align_check u_align_check (
        .wen_i        (acc_wen),
        .addr_lo_i    (acc_addr[1:0]),
        .misaligned_o (chk_misaligned)
    );

    // Loads are never flagged
    assign acc_misaligned = acc_is_write && chk_misaligned;
`else
    assign acc_misaligned = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.rvalid   = (state_q == RESP);
        bus.stall    = bus.req && (state_q != RESP);
        bus.rdata    = rdata_q;
        bus.addr_err = err_q;
    end

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= bus.addr[ADDR_W+1:0];
            wen_q   <= bus.wen;
            wdata_q <= bus.wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read data and error flag; both only change on the RESP entry edge.
    // err_q is therefore high exactly in the RESP cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= access && acc_misaligned;
            if (access && !acc_is_write) begin
                rdata_q <= mem[acc_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM write port; a reset on the access edge discards the write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && access && acc_is_write && !acc_misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder.
//               u_dut2 runs with WAIT_CYCLES=2, u_dut0 with WAIT_CYCLES=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2), .CNT_W(4)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .CNT_W(4)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driving helpers ----------------
    task automatic drive(input bit use0, input logic req, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (use0) begin
            bus0.req = req; bus0.wen = wen; bus0.addr = addr; bus0.wdata = wdata;
        end else begin
            bus2.req = req; bus2.wen = wen; bus2.addr = addr; bus2.wdata = wdata;
        end
    endtask

    function automatic logic get_stall(input bit use0);
        return use0 ? bus0.stall : bus2.stall;
    endfunction

    function automatic logic get_rvalid(input bit use0);
        return use0 ? bus0.rvalid : bus2.rvalid;
    endfunction

    // One complete CPU access: req held until rvalid is seen.
    // lat = cycles from the accept cycle to the rvalid cycle (-1 on timeout).
    task automatic access(input bit use0, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int stalls, output int lat,
                          output logic [31:0] rd, output logic err);
        bit got;
        int n;
        @(posedge clk); #1;
        drive(use0, 1'b1, wen, addr, wdata);
        got = 1'b0; stalls = 0; lat = -1; rd = '0; err = 1'b0; n = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (get_stall(use0)) stalls++;
            if (get_rvalid(use0)) begin
                got = 1'b1;
                lat = n;
                rd  = use0 ? bus0.rdata : bus2.rdata;
                err = use0 ? bus0.addr_err : bus2.addr_err;
            end
            n++;
        end
        @(posedge clk); #1;
        drive(use0, 1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus2.rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %b want 0", bus2.rvalid); end
        vectors++;
        if (bus2.stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", bus2.stall); end
        vectors++;
        if (bus2.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 00000000", bus2.rdata); end
        vectors++;
        if (bus2.addr_err !== 1'b0) begin miscompares++; $display("FAIL reset_addr_err got %b want 0", bus2.addr_err); end
        vectors++;
        if (bus0.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata0 got %h want 00000000", bus0.rdata); end
    endtask

    task automatic test_store_load();
        int s, l; logic [31:0] rd; logic e;
        access(1'b0, 4'b1111, 32'h40, 32'hDEADBEEF, s, l, rd, e);
        vectors++;
        if (s !== 3) begin miscompares++; $display("FAIL store_stalls got %0d want 3", s); end
        vectors++;
        if (l !== 3) begin miscompares++; $display("FAIL store_latency got %0d want 3", l); end
        access(1'b0, 4'b0000, 32'h40, 32'h0, s, l, rd, e);
        vectors++;
        if (s !== 3) begin miscompares++; $display("FAIL load_stalls got %0d want 3", s); end
        vectors++;
        if (l !== 3) begin miscompares++; $display("FAIL load_latency got %0d want 3", l); end
        vectors++;
        if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_rdata got %h want DEADBEEF", rd); end
    endtask

    task automatic test_byte_lane();
        int s, l; logic [31:0] rd; logic e;
        access(1'b0, 4'b0100, 32'h42, 32'h00AA0000, s, l, rd, e);
        vectors++;
        if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rdata_hold_on_write got %h want DEADBEEF", rd); end
        access(1'b0, 4'b0000, 32'h40, 32'h0, s, l, rd, e);
        vectors++;
        if (rd !== 32'hDEAABEEF) begin miscompares++; $display("FAIL byte_lane got %h want DEAABEEF", rd); end
    endtask

    task automatic test_align();
        int s, l; logic [31:0] rd; logic e;
        access(1'b0, 4'b1111, 32'h41, 32'h55555555, s, l, rd, e);
        vectors++;
        if (e !== ALIGN_EN) begin miscompares++; $display("FAIL misaligned_word_err got %b want %b", e, ALIGN_EN); end
        access(1'b0, 4'b0000, 32'h40, 32'h0, s, l, rd, e);
        vectors++;
        if (rd !== (ALIGN_EN ? 32'hDEAABEEF : 32'h55555555)) begin
            miscompares++;
            $display("FAIL misaligned_word_data got %h want %h", rd, ALIGN_EN ? 32'hDEAABEEF : 32'h55555555);
        end
        access(1'b0, 4'b1100, 32'h42, 32'h77770000, s, l, rd, e);
        vectors++;
        if (e !== 1'b0) begin miscompares++; $display("FAIL aligned_half_err got %b want 0", e); end
        // Load from an odd byte address: loads are never flagged
        access(1'b0, 4'b0000, 32'h43, 32'h0, s, l, rd, e);
        vectors++;
        if (e !== 1'b0) begin miscompares++; $display("FAIL load_err got %b want 0", e); end
        vectors++;
        if (rd !== (ALIGN_EN ? 32'h7777BEEF : 32'h77775555)) begin
            miscompares++;
            $display("FAIL aligned_half_data got %h want %h", rd, ALIGN_EN ? 32'h7777BEEF : 32'h77775555);
        end
    endtask

    task automatic test_alias();
        int s, l; logic [31:0] rd; logic e;
        access(1'b0, 4'b1111, 32'h1000, 32'hA5A5A5A5, s, l, rd, e);
        access(1'b0, 4'b0000, 32'h0, 32'h0, s, l, rd, e);
        vectors++;
        if (rd !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL alias got %h want A5A5A5A5", rd); end
    endtask

    task automatic test_flush();
        int pulses, stalls; int s, l; logic [31:0] rd; logic e;
        pulses = 0; stalls = 0;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 4'b1111, 32'h100, 32'h0BADF00D);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        repeat (6) begin
            @(negedge clk);
            if (bus2.rvalid) pulses++;
            if (bus2.stall) stalls++;
        end
        vectors++;
        if (pulses !== 1) begin miscompares++; $display("FAIL flush_rvalid_pulses got %0d want 1", pulses); end
        vectors++;
        if (stalls !== 0) begin miscompares++; $display("FAIL flush_stall got %0d want 0", stalls); end
        access(1'b0, 4'b0000, 32'h100, 32'h0, s, l, rd, e);
        vectors++;
        if (rd !== 32'h0BADF00D) begin miscompares++; $display("FAIL flush_write got %h want 0BADF00D", rd); end
    endtask

    task automatic test_back_to_back();
        int s, l; logic [31:0] rd; logic e;
        access(1'b1, 4'b1111, 32'h0, 32'h11111111, s, l, rd, e);
        vectors++;
        if (s !== 1) begin miscompares++; $display("FAIL zw_stalls got %0d want 1", s); end
        vectors++;
        if (l !== 1) begin miscompares++; $display("FAIL zw_latency got %0d want 1", l); end
        access(1'b1, 4'b1111, 32'h4, 32'h22222222, s, l, rd, e);
        // Continuous req: load 0x0 then load 0x4
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        vectors++;
        if ({bus0.stall, bus0.rvalid} !== 2'b10) begin miscompares++; $display("FAIL b2b_c0 stall,rvalid got %b want 10", {bus0.stall, bus0.rvalid}); end
        @(negedge clk);
        vectors++;
        if ({bus0.stall, bus0.rvalid} !== 2'b01) begin miscompares++; $display("FAIL b2b_c1 stall,rvalid got %b want 01", {bus0.stall, bus0.rvalid}); end
        vectors++;
        if (bus0.rdata !== 32'h11111111) begin miscompares++; $display("FAIL b2b_rdata0 got %h want 11111111", bus0.rdata); end
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 4'b0000, 32'h4, 32'h0);
        @(negedge clk);
        vectors++;
        if ({bus0.stall, bus0.rvalid} !== 2'b10) begin miscompares++; $display("FAIL b2b_c2 stall,rvalid got %b want 10", {bus0.stall, bus0.rvalid}); end
        @(negedge clk);
        vectors++;
        if ({bus0.stall, bus0.rvalid} !== 2'b01) begin miscompares++; $display("FAIL b2b_c3 stall,rvalid got %b want 01", {bus0.stall, bus0.rvalid}); end
        vectors++;
        if (bus0.rdata !== 32'h22222222) begin miscompares++; $display("FAIL b2b_rdata1 got %h want 22222222", bus0.rdata); end
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        vectors++;
        if (bus0.rvalid !== 1'b0) begin miscompares++; $display("FAIL b2b_no_double got %b want 0", bus0.rvalid); end
    endtask

    task automatic test_reset_mid_access();
        int s, l; logic [31:0] rd; logic e; int pulses;
        access(1'b0, 4'b1111, 32'h80, 32'hCAFEF00D, s, l, rd, e);
        pulses = 0;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 4'b1111, 32'h80, 32'h12345678);
        @(posedge clk); #1;              // accepted, now in WAIT
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        if (bus2.rvalid) pulses++;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus2.rvalid) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin miscompares++; $display("FAIL rst_mid_rvalid got %0d pulses want 0", pulses); end
        vectors++;
        if (bus2.rdata !== 32'h0) begin miscompares++; $display("FAIL rst_mid_rdata got %h want 00000000", bus2.rdata); end
        access(1'b0, 4'b0000, 32'h80, 32'h0, s, l, rd, e);
        vectors++;
        if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL rst_mid_ram got %h want CAFEF00D", rd); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_store_load();
        test_byte_lane();
        test_align();
        test_alias();
        test_flush();
        test_back_to_back();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
